// File: rtl/mem_lsu.sv
// Memory stage: drives data-bus load/store transactions, aligns store data,
// formats load data, detects misaligned and timed-out accesses and owns the
// MEM/WB pipeline register.
module mem_lsu #(
    parameter int unsigned DBUS_TIMEOUT = 255,
    parameter int unsigned TMO_W        = 16
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        ex2mem_wr_reg_ffout,
    input  logic [4:0]  ex2mem_wr_regindex_ffout,
    input  logic [31:0] ex2mem_wr_wdata_ffout,
    input  logic [31:0] ex2mem_memaddr_ffout,
    input  logic [31:0] ex2mem_wr_memwdata_ffout,
    input  logic [2:0]  ex2mem_mem_op_ffout,
    input  logic        ex2mem_mem_en_ffout,
    input  logic        ex2mem_load_ffout,
    input  logic        ex2mem_store_ffout,
    input  logic        ex2mem_exp_ffout,
    input  logic [31:0] ex2mem_pc_ffout,
    input  logic        ex2mem_wr_csrreg_ffout,
    input  logic [11:0] ex2mem_wr_csrindex_ffout,
    input  logic [31:0] ex2mem_wr_csrwdata_ffout,
    input  logic        ex2mem_mret_ffout,
    input  logic        interrupt,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    output logic        mem_stall,
    output logic        mem2wb_wr_reg_ffout,
    output logic [4:0]  mem2wb_wr_regindex_ffout,
    output logic [31:0] mem2wb_wr_wdata_ffout,
    output logic        mem2wb_exp_ffout,
    output logic [3:0]  mem2wb_cause_ffout,
    output logic [31:0] mem2wb_badaddr_ffout,
    output logic [31:0] mem2wb_pc_ffout,
    output logic        mem2wb_wr_csrreg_ffout,
    output logic [11:0] mem2wb_wr_csrindex_ffout,
    output logic [31:0] mem2wb_wr_csrwdata_ffout,
    output logic        mem2wb_mret_ffout
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    // Counter value seen in the last allowed cycle of REQ/WAIT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DBUS_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              flush_q, flush_d;

    logic        flush, misalign, access, timeout;
    logic        req, fault;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] ld_shift, ld_data;

    logic [1:0] a_lo;
    assign a_lo = ex2mem_memaddr_ffout[1:0];

    assign flush    = mem2wb_exp_ffout | interrupt;
    assign misalign = ex2mem_mem_en_ffout &
                      (((ex2mem_mem_op_ffout[1:0] == 2'b01) & a_lo[0]) |
                       ((ex2mem_mem_op_ffout[1:0] == 2'b10) & (a_lo != 2'b00)));
    assign access   = ex2mem_mem_en_ffout & ~ex2mem_exp_ffout & ~misalign & ~flush;
    assign timeout  = (DBUS_TIMEOUT != 0) && (state_q != IDLE) && (tmo_q == TMO_LAST);

    // Bus transaction FSM: next state, request and stall.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        mem_stall = 1'b0;
        fault     = 1'b0;
        case (state_q)
            IDLE: begin
                req       = access;
                mem_stall = access & ~(ex2mem_store_ffout & dbus_gnt);
                if (access) begin
                    if (dbus_gnt) state_d = ex2mem_store_ffout ? IDLE : WAIT;
                    else          state_d = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (dbus_gnt) begin
                    state_d   = ex2mem_store_ffout ? IDLE : WAIT;
                    mem_stall = ~ex2mem_store_ffout;
                end else if (timeout) begin
                    state_d = IDLE;
                    fault   = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            WAIT: begin
                if (dbus_rvalid) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    fault   = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter restarts on every entry to REQ/WAIT; the flush flag
    // remembers a flush seen mid-transaction until the transaction completes.
    always_comb begin
        if (state_d == IDLE || state_d != state_q) tmo_d = '0;
        else                                       tmo_d = tmo_q + TMO_W'(1);
        if (state_q != IDLE && state_d != IDLE)    flush_d = flush_q | flush;
        else                                       flush_d = 1'b0;
    end

    // FSM state, timeout counter and flush flag registers.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            flush_q <= flush_d;
        end
    end

    // Store lane alignment: byte enables and replicated write data.
    always_comb begin
        be       = 4'b1111;
        wdata_al = ex2mem_wr_memwdata_ffout;
        case (ex2mem_mem_op_ffout[1:0])
            2'b00: begin
                be       = 4'b0001 << a_lo;
                wdata_al = {4{ex2mem_wr_memwdata_ffout[7:0]}};
            end
            2'b01: begin
                be       = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{ex2mem_wr_memwdata_ffout[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting: shift the addressed lane down, then extend.
    always_comb begin
        ld_shift = dbus_rdata >> {a_lo, 3'b000};
        case (ex2mem_mem_op_ffout)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Bus outputs are forced low while reset is held.
    assign dbus_req   = req & ~cpurst;
    assign dbus_we    = ex2mem_store_ffout & ~cpurst;
    assign dbus_addr  = cpurst ? 32'h0 : {ex2mem_memaddr_ffout[31:2], 2'b00};
    assign dbus_be    = cpurst ? 4'h0 : be;
    assign dbus_wdata = cpurst ? 32'h0 : wdata_al;

    // MEM/WB register: NOP on flush, fault/exception records, else pass-through.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mem2wb_wr_reg_ffout      <= 1'b0;
            mem2wb_wr_regindex_ffout <= '0;
            mem2wb_wr_wdata_ffout    <= '0;
            mem2wb_exp_ffout         <= 1'b0;
            mem2wb_cause_ffout       <= '0;
            mem2wb_badaddr_ffout     <= '0;
            mem2wb_pc_ffout          <= '0;
            mem2wb_wr_csrreg_ffout   <= 1'b0;
            mem2wb_wr_csrindex_ffout <= '0;
            mem2wb_wr_csrwdata_ffout <= '0;
            mem2wb_mret_ffout        <= 1'b0;
        end else if (!mem_stall) begin
            mem2wb_wr_reg_ffout      <= 1'b0;
            mem2wb_wr_regindex_ffout <= '0;
            mem2wb_wr_wdata_ffout    <= '0;
            mem2wb_exp_ffout         <= 1'b0;
            mem2wb_cause_ffout       <= '0;
            mem2wb_badaddr_ffout     <= '0;
            mem2wb_pc_ffout          <= '0;
            mem2wb_wr_csrreg_ffout   <= 1'b0;
            mem2wb_wr_csrindex_ffout <= '0;
            mem2wb_wr_csrwdata_ffout <= '0;
            mem2wb_mret_ffout        <= 1'b0;
            if (flush | flush_q) begin
                // leave the NOP written above
            end else if (fault | misalign) begin
                mem2wb_exp_ffout     <= 1'b1;
                mem2wb_cause_ffout   <= fault ? (ex2mem_load_ffout ? 4'd5 : 4'd7)
                                              : (ex2mem_load_ffout ? 4'd4 : 4'd6);
                mem2wb_badaddr_ffout <= ex2mem_memaddr_ffout;
                mem2wb_pc_ffout      <= ex2mem_pc_ffout;
            end else if (ex2mem_exp_ffout) begin
                mem2wb_exp_ffout <= 1'b1;
                mem2wb_pc_ffout  <= ex2mem_pc_ffout;
            end else begin
                mem2wb_wr_reg_ffout      <= ex2mem_wr_reg_ffout;
                mem2wb_wr_regindex_ffout <= ex2mem_wr_regindex_ffout;
                mem2wb_wr_wdata_ffout    <= ex2mem_load_ffout ? ld_data : ex2mem_wr_wdata_ffout;
                mem2wb_pc_ffout          <= ex2mem_pc_ffout;
                mem2wb_wr_csrreg_ffout   <= ex2mem_wr_csrreg_ffout;
                mem2wb_wr_csrindex_ffout <= ex2mem_wr_csrindex_ffout;
                mem2wb_wr_csrwdata_ffout <= ex2mem_wr_csrwdata_ffout;
                mem2wb_mret_ffout        <= ex2mem_mret_ffout;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu (instantiated with a short bus timeout).
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        wr_reg, mem_en, load, store, exp_in, csrreg, mret, interrupt;
    logic [4:0]  regidx;
    logic [31:0] wdata, addr, memwdata, pc, csrwdata;
    logic [2:0]  op;
    logic [11:0] csridx;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    logic        dbus_req, dbus_we, mem_stall;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        o_wr_reg, o_exp, o_csrreg, o_mret;
    logic [4:0]  o_regidx;
    logic [31:0] o_wdata, o_badaddr, o_pc, o_csrwdata;
    logic [3:0]  o_cause;
    logic [11:0] o_csridx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_lsu #(.DBUS_TIMEOUT(4), .TMO_W(16)) dut (
        .clk(clk), .cpurst(cpurst),
        .ex2mem_wr_reg_ffout(wr_reg), .ex2mem_wr_regindex_ffout(regidx),
        .ex2mem_wr_wdata_ffout(wdata), .ex2mem_memaddr_ffout(addr),
        .ex2mem_wr_memwdata_ffout(memwdata), .ex2mem_mem_op_ffout(op),
        .ex2mem_mem_en_ffout(mem_en), .ex2mem_load_ffout(load),
        .ex2mem_store_ffout(store), .ex2mem_exp_ffout(exp_in),
        .ex2mem_pc_ffout(pc), .ex2mem_wr_csrreg_ffout(csrreg),
        .ex2mem_wr_csrindex_ffout(csridx), .ex2mem_wr_csrwdata_ffout(csrwdata),
        .ex2mem_mret_ffout(mret), .interrupt(interrupt),
        .dbus_gnt(gnt), .dbus_rvalid(rvalid), .dbus_rdata(rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .mem_stall(mem_stall),
        .mem2wb_wr_reg_ffout(o_wr_reg), .mem2wb_wr_regindex_ffout(o_regidx),
        .mem2wb_wr_wdata_ffout(o_wdata), .mem2wb_exp_ffout(o_exp),
        .mem2wb_cause_ffout(o_cause), .mem2wb_badaddr_ffout(o_badaddr),
        .mem2wb_pc_ffout(o_pc), .mem2wb_wr_csrreg_ffout(o_csrreg),
        .mem2wb_wr_csrindex_ffout(o_csridx), .mem2wb_wr_csrwdata_ffout(o_csrwdata),
        .mem2wb_mret_ffout(o_mret)
    );

    task automatic bubble();
        wr_reg = 0; mem_en = 0; load = 0; store = 0; exp_in = 0; csrreg = 0;
        mret = 0; interrupt = 0; regidx = 0; wdata = 0; addr = 0; memwdata = 0;
        pc = 0; csrwdata = 0; op = 0; csridx = 0; gnt = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_mem(input logic is_load, input logic [2:0] f3, input logic [31:0] a);
        bubble();
        mem_en = 1; load = is_load; store = ~is_load; op = f3; addr = a;
    endtask

    task automatic test_reset();
        bubble();
        cpurst = 1;
        set_mem(1, 3'b010, 32'h100);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", dbus_req); end
        checks++; if (o_wr_reg !== 1'b0 || o_exp !== 1'b0) begin errors++; $display("FAIL reset_mem2wb got=%0h/%0h exp=0/0", o_wr_reg, o_exp); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", o_pc); end
        bubble();
        cpurst = 0;
        next_cycle();
    endtask

    task automatic test_alu();
        bubble();
        wr_reg = 1; regidx = 5; wdata = 32'hDEADBEEF; pc = 32'h40;
        csrreg = 1; csridx = 12'h305; csrwdata = 32'h11; mret = 1;
        mid();
        checks++; if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL alu_nostall got=%0h/%0h exp=0/0", mem_stall, dbus_req); end
        next_cycle();
        checks++; if (o_wr_reg !== 1'b1 || o_regidx !== 5'd5 || o_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rd got=%0h/%0d/%0h exp=1/5/deadbeef", o_wr_reg, o_regidx, o_wdata); end
        checks++; if (o_pc !== 32'h40 || o_csrreg !== 1'b1 || o_csridx !== 12'h305 || o_csrwdata !== 32'h11 || o_mret !== 1'b1) begin errors++; $display("FAIL alu_csr got=%0h/%0h/%0h/%0h/%0h exp=40/1/305/11/1", o_pc, o_csrreg, o_csridx, o_csrwdata, o_mret); end
        bubble();
    endtask

    task automatic test_load_lw();
        set_mem(1, 3'b010, 32'h100);
        wr_reg = 1; regidx = 10; gnt = 1;
        mid();
        checks++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h100 || dbus_we !== 1'b0) begin errors++; $display("FAIL lw_req got=%0h/%0h/%0h exp=1/100/0", dbus_req, dbus_addr, dbus_we); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_stall0 got=%0h exp=1", mem_stall); end
        next_cycle();
        gnt = 0; rvalid = 1; rdata = 32'h8899AABB;
        mid();
        checks++; if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL lw_wait got=%0h/%0h exp=0/0", mem_stall, dbus_req); end
        next_cycle();
        checks++; if (o_wdata !== 32'h8899AABB || o_wr_reg !== 1'b1 || o_regidx !== 5'd10) begin errors++; $display("FAIL lw_data got=%0h/%0h/%0d exp=8899aabb/1/10", o_wdata, o_wr_reg, o_regidx); end
        bubble();
    endtask

    task automatic test_load_format();
        logic [2:0]  ops [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] adr [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [31:0] expv[5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h00000033};
        for (int i = 0; i < 5; i++) begin
            set_mem(1, ops[i], adr[i]);
            wr_reg = 1; regidx = 1; gnt = 1;
            next_cycle();
            gnt = 0; rvalid = 1; rdata = 32'h80112233;
            next_cycle();
            checks++; if (o_wdata !== expv[i]) begin errors++; $display("FAIL ld_fmt%0d got=%0h exp=%0h", i, o_wdata, expv[i]); end
        end
        bubble();
    endtask

    task automatic test_store();
        set_mem(0, 3'b001, 32'h6);
        memwdata = 32'h1234; pc = 32'h50;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++; if (mem_stall !== 1'b1 || dbus_req !== 1'b1) begin errors++; $display("FAIL sh_stall%0d got=%0h/%0h exp=1/1", i, mem_stall, dbus_req); end
            checks++; if (dbus_addr !== 32'h4 || dbus_be !== 4'b1100 || dbus_wdata !== 32'h12341234 || dbus_we !== 1'b1) begin errors++; $display("FAIL sh_bus%0d got=%0h/%0b/%0h/%0h exp=4/1100/12341234/1", i, dbus_addr, dbus_be, dbus_wdata, dbus_we); end
            next_cycle();
        end
        gnt = 1;
        mid();
        checks++; if (mem_stall !== 1'b0 || dbus_req !== 1'b1) begin errors++; $display("FAIL sh_gnt got=%0h/%0h exp=0/1", mem_stall, dbus_req); end
        next_cycle();
        checks++; if (o_pc !== 32'h50 || o_wr_reg !== 1'b0 || o_exp !== 1'b0) begin errors++; $display("FAIL sh_retire got=%0h/%0h/%0h exp=50/0/0", o_pc, o_wr_reg, o_exp); end
        set_mem(0, 3'b000, 32'h101);
        memwdata = 32'h000000AB; gnt = 1;
        mid();
        checks++; if (dbus_be !== 4'b0010 || dbus_wdata !== 32'hABABABAB || mem_stall !== 1'b0) begin errors++; $display("FAIL sb_bus got=%0b/%0h/%0h exp=0010/abababab/0", dbus_be, dbus_wdata, mem_stall); end
        next_cycle();
        set_mem(0, 3'b010, 32'h200);
        memwdata = 32'hCAFEF00D; gnt = 1;
        mid();
        checks++; if (dbus_be !== 4'b1111 || dbus_wdata !== 32'hCAFEF00D || dbus_addr !== 32'h200 || mem_stall !== 1'b0) begin errors++; $display("FAIL sw_bus got=%0b/%0h/%0h/%0h exp=1111/cafef00d/200/0", dbus_be, dbus_wdata, dbus_addr, mem_stall); end
        next_cycle();
        bubble();
        mid();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL st_idle got=%0h exp=0", dbus_req); end
        next_cycle();
    endtask

    task automatic test_misalign();
        set_mem(1, 3'b010, 32'h2);
        wr_reg = 1; regidx = 3; pc = 32'h80;
        mid();
        checks++; if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL mis_lw_bus got=%0h/%0h exp=0/0", dbus_req, mem_stall); end
        next_cycle();
        checks++; if (o_exp !== 1'b1 || o_cause !== 4'd4 || o_badaddr !== 32'h2 || o_wr_reg !== 1'b0 || o_pc !== 32'h80) begin errors++; $display("FAIL mis_lw got=%0h/%0d/%0h/%0h/%0h exp=1/4/2/0/80", o_exp, o_cause, o_badaddr, o_wr_reg, o_pc); end
        bubble();
        next_cycle();
        checks++; if (o_exp !== 1'b0) begin errors++; $display("FAIL mis_nop got=%0h exp=0", o_exp); end
        set_mem(0, 3'b001, 32'h5);
        mid();
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL mis_sh_req got=%0h exp=0", dbus_req); end
        next_cycle();
        checks++; if (o_exp !== 1'b1 || o_cause !== 4'd6 || o_badaddr !== 32'h5) begin errors++; $display("FAIL mis_sh got=%0h/%0d/%0h exp=1/6/5", o_exp, o_cause, o_badaddr); end
        bubble();
        next_cycle();
        set_mem(1, 3'b010, 32'h100);
        exp_in = 1; pc = 32'h90; wr_reg = 1;
        mid();
        checks++; if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL upexp_bus got=%0h/%0h exp=0/0", dbus_req, mem_stall); end
        next_cycle();
        checks++; if (o_exp !== 1'b1 || o_cause !== 4'd0 || o_wr_reg !== 1'b0 || o_pc !== 32'h90) begin errors++; $display("FAIL upexp got=%0h/%0d/%0h/%0h exp=1/0/0/90", o_exp, o_cause, o_wr_reg, o_pc); end
        bubble();
        next_cycle();
    endtask

    task automatic test_timeout();
        set_mem(1, 3'b010, 32'h300);
        wr_reg = 1; gnt = 1;
        next_cycle();
        gnt = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL tmo_ld_wait%0d got=%0h exp=1", i, mem_stall); end
            next_cycle();
        end
        mid();
        checks++; if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL tmo_ld_end got=%0h/%0h exp=0/0", mem_stall, dbus_req); end
        next_cycle();
        checks++; if (o_exp !== 1'b1 || o_cause !== 4'd5 || o_badaddr !== 32'h300 || o_wr_reg !== 1'b0) begin errors++; $display("FAIL tmo_ld got=%0h/%0d/%0h/%0h exp=1/5/300/0", o_exp, o_cause, o_badaddr, o_wr_reg); end
        bubble();
        next_cycle();
        wr_reg = 1; regidx = 7; wdata = 32'h55; rvalid = 1; rdata = 32'hFFFFFFFF;
        mid();
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL tmo_late_stall got=%0h exp=0", mem_stall); end
        next_cycle();
        checks++; if (o_wdata !== 32'h55 || o_exp !== 1'b0 || o_regidx !== 5'd7) begin errors++; $display("FAIL tmo_late got=%0h/%0h/%0d exp=55/0/7", o_wdata, o_exp, o_regidx); end
        set_mem(0, 3'b010, 32'h310);
        for (int i = 0; i < 4; i++) begin
            mid();
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL tmo_st_wait%0d got=%0h exp=1", i, mem_stall); end
            next_cycle();
        end
        mid();
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL tmo_st_end got=%0h exp=0", mem_stall); end
        next_cycle();
        checks++; if (o_exp !== 1'b1 || o_cause !== 4'd7 || o_badaddr !== 32'h310) begin errors++; $display("FAIL tmo_st got=%0h/%0d/%0h exp=1/7/310", o_exp, o_cause, o_badaddr); end
        bubble();
        gnt = 1;
        mid();
        checks++; if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL tmo_late_gnt got=%0h/%0h exp=0/0", dbus_req, mem_stall); end
        next_cycle();
        bubble();
    endtask

    task automatic test_flush();
        bubble();
        wr_reg = 1; regidx = 9; wdata = 32'h99;
        next_cycle();
        set_mem(1, 3'b010, 32'h400);
        wr_reg = 1; regidx = 9; gnt = 1;
        next_cycle();
        gnt = 0; interrupt = 1;
        mid();
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_stall0 got=%0h exp=1", mem_stall); end
        next_cycle();
        interrupt = 0;
        mid();
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_stall1 got=%0h exp=1", mem_stall); end
        next_cycle();
        rvalid = 1; rdata = 32'h12345678;
        mid();
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL fl_rvalid got=%0h exp=0", mem_stall); end
        next_cycle();
        checks++; if (o_wr_reg !== 1'b0 || o_wdata !== 32'h0 || o_exp !== 1'b0 || o_regidx !== 5'd0) begin errors++; $display("FAIL fl_nop got=%0h/%0h/%0h/%0d exp=0/0/0/0", o_wr_reg, o_wdata, o_exp, o_regidx); end
        bubble();
    endtask

    task automatic test_reset_in_req();
        bubble();
        wr_reg = 1; pc = 32'h77;
        next_cycle();
        set_mem(0, 3'b010, 32'h500);
        next_cycle();
        mid();
        checks++; if (dbus_req !== 1'b1 || o_pc !== 32'h77) begin errors++; $display("FAIL rq_before got=%0h/%0h exp=1/77", dbus_req, o_pc); end
        #1 cpurst = 1;
        #1;
        checks++; if (dbus_req !== 1'b0 || o_pc !== 32'h0) begin errors++; $display("FAIL rq_reset got=%0h/%0h exp=0/0", dbus_req, o_pc); end
        next_cycle();
        cpurst = 0;
        bubble();
        mid();
        checks++; if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rq_idle got=%0h/%0h exp=0/0", dbus_req, mem_stall); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_lw();
        test_load_format();
        test_store();
        test_misalign();
        test_timeout();
        test_flush();
        test_reset_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
